// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared defaults for the integer register bank
// Purpose: default widths/depth of the register file and the hardwired-zero
//          register address. Imported by rtl/reg_bank.sv.
// Ports: none (package).
package reg_bank_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int CW_DEF   = 32;

  // Address of x0; reads return zero and writes are discarded.
  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - RV32 integer register file with committed-write counter
// Purpose: NREG x XLEN register file, two combinational read ports plus a
//          debug read port, one synchronous write port, x0 hardwired to zero,
//          and a wrapping counter of committed writes.
// Optional: macro REG_BANK_BYPASS_EN enables write-through forwarding of wd3
//           onto any read port whose address matches a committing a3.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   a1, a2   in   read addresses (rs1, rs2)
//   a3       in   write address (rd)
//   we3      in   write enable
//   wd3      in   write-back data
//   rd1, rd2 out  read data
//   dbg_addr in   debug read address
//   dbg_data out  debug read data
//   wr_count out  committed writes since reset, wraps modulo 2^CW
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic            we3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [CW-1:0]   wr_count
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREG];

  // we3 gates the whole commit term, so an X on a3 with we3=0 cannot
  // select any register or bump the counter.
  logic commit;
  assign commit = we3 && (a3 != ZERO_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[a3] <= wd3;
      wr_count <= wr_count + CW'(1);
    end
  end

  // Forwarding source. Without the bypass build both terms are constant
  // zero, so no path exists from wd3 to the read ports.
  logic            fwd_ok;
  logic [XLEN-1:0] fwd_data;
`ifdef REG_BANK_BYPASS_EN
  assign fwd_ok   = commit;
  assign fwd_data = wd3;
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  // One read port: x0 masking wins over forwarding, forwarding wins over
  // the stored value.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            fwd_hit,
    input logic [XLEN-1:0] fwd_val
  );
    if (addr == ZERO_ADDR) return '0;
    if (fwd_hit) return fwd_val;
    return stored;
  endfunction

  always_comb begin
    rd1 = read_port(a1, regs[a1], fwd_ok && (a1 == a3), fwd_data);
  end

  always_comb begin
    rd2 = read_port(a2, regs[a2], fwd_ok && (a2 == a3), fwd_data);
  end

  always_comb begin
    dbg_data = read_port(dbg_addr, regs[dbg_addr], fwd_ok && (dbg_addr == a3), fwd_data);
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Integer register file of the single-cycle RV32 datapath, directly downstream of the instruction register-address decoder.
- Consumes the decoded source addresses a1/a2 and destination address a3, and drives operands rd1/rd2 to the ALU/store path.
- Accepts the write-back value wd3 from the result mux.
- Holds 32 architectural registers; x0 is hardwired to zero. Also keeps a committed-write counter for debug and performance use.

Parameters:
- XLEN, 32, data width of each register and of the read/write ports.
- NREG, 32, number of architectural registers; must be a power of two.
- AW, 5, address width; must equal log2(NREG).
- CW, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a1  input  AW  read address, port 1 (rs1).
- a2  input  AW  read address, port 2 (rs2).
- a3  input  AW  write address (rd).
- we3  input  1  write enable (regWrite from control).
- wd3  input  XLEN  write-back data.
- rd1  output  XLEN  read data, port 1.
- rd2  output  XLEN  read data, port 2.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  XLEN  debug read data.
- wr_count  output  CW  number of committed writes since reset.

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is asynchronous and active-high.
- While rst=1: all NREG registers read 0 and wr_count=0, immediately and without waiting for a clock edge.
- While rst=1: rd1, rd2 and dbg_data therefore read 0 for every address.
- Reads are combinational with zero latency. rd1=R[a1], rd2=R[a2], dbg_data=R[dbg_addr].
- Any read of address 0 returns 0 regardless of stored contents.
- Write: on a rising clk edge with rst=0, we3=1 and a3!=0, R[a3] takes wd3.
- A write with a3=0 is discarded; x0 stays 0.
- The new value is visible on the read ports after the edge.
- we3=0: no state change, even when a3 is unknown/X. The decoder drives X on unused address fields, and the bank must not corrupt state in that case.
- An X on a1 or a2 yields don't-care on rd1/rd2. Verification must not check rd values for X addresses.
- Read-during-write, same address, same cycle, feature disabled: rd returns the old value until the edge.
- wr_count increments by 1 on each edge where a write commits (we3=1, a3!=0, rst=0).
- wr_count wraps modulo 2^CW from all-ones to 0, with no saturation.
- Writes with a3=0 do not count.
- Reset asserted mid-cycle: contents and counter clear asynchronously. A write coinciding with reset is lost.
- First commit edge after reset deassertion: a write is accepted on the first rising edge at which rst is sampled 0.
- No internal state machine beyond storage and the counter. Single-cycle datapath; no stalls or handshakes.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined: write-through forwarding. When we3=1, a3!=0 and a1==a3, rd1=wd3 combinationally in the same cycle. Same rule for rd2/a2 and dbg_data/dbg_addr.
- Defined, a3=0: never forwards.
- Not defined: reads always return stored contents; no path from wd3 to the read ports.

Decomposition:
- Shared package/header holds XLEN, NREG and AW defaults.
- Shared package also holds the constant REG_ZERO = 0.
- No sub-module needed. Storage array, write logic, read muxes and counter live in one module.
- The read mux with x0 masking and optional bypass is replicated three times, as a function or generate loop.

Test Plan:
- Reset check: assert rst=1 mid-cycle with arbitrary contents -> rd1, rd2 and dbg_data = 0 for addresses 1..31, wr_count=0, with no clock edge needed.
- Basic write/read: we3=1, a3=5, wd3=0xDEADBEEF, one edge; then a1=5, a2=5 -> rd1=rd2=0xDEADBEEF, wr_count=1.
- x0 protection: we3=1, a3=0, wd3=0xFFFFFFFF, edge; a1=0 -> rd1=0, wr_count unchanged.
- X-address immunity: we3=0, a3=X, wd3=0x12345678, edge -> all 32 registers unchanged (checked via dbg port), wr_count unchanged.
- Read-during-write: R[7]=0x11; we3=1, a3=7, wd3=0x22, a1=7 before edge -> rd1=0x11 without the macro, 0x22 with REG_BANK_BYPASS_EN; 0x22 after the edge in both builds.
- Counter wrap: CW=4, 17 commits to a3=3 -> wr_count=1; interleaved a3=0 writes do not change it.
